// File: rtl/shift_demux_pkg.sv
// Shared types and sizing helpers for the shift_demux deserializer.
// The SHIFT_DEMUX_PARITY_EN macro is consumed by the top module, not here.
package shift_demux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter width able to hold the value 'width' itself.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_demux_deser_shift_in_reg.sv
// Right-shift register with serial MSB-side input, enable and synchronous clear.
// Mirrors the upstream shift-select path that emits bit [0] first.
module shift_in_reg
  import shift_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Clear wins over a shift so a finished word never leaks into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_demux_deser.sv
// Serial-to-parallel receiver: collects LSB-first bits and presents whole words.
// Define SHIFT_DEMUX_PARITY_EN to expect a trailing even-parity bit and add out_perr.
module shift_demux_deser
  import shift_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
`ifdef SHIFT_DEMUX_PARITY_EN
  localparam int CNT_W = calc_cnt_w(WIDTH + 1)
`else
  localparam int CNT_W = calc_cnt_w(WIDTH)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
`ifdef SHIFT_DEMUX_PARITY_EN
  ,
  output logic             out_perr
`endif
);

`ifdef SHIFT_DEMUX_PARITY_EN
  localparam int TOTAL = WIDTH + 1;
`else
  localparam int TOTAL = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  state_t           state_q;
  state_t           state_d;
  logic             ready_en;
  logic [WIDTH-1:0] sr_q;
  logic             accept;
  logic             last_bit;
  logic             handshake;
  logic             shift_en;

  assign in_ready  = ready_en && (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign last_bit  = accept && (bit_cnt == LAST_IDX);
  assign handshake = out_valid && out_ready;
  assign busy      = (bit_cnt != '0);

`ifdef SHIFT_DEMUX_PARITY_EN
  // The trailing parity bit is only checked, never shifted into the word.
  assign shift_en = accept && !last_bit;
`else
  assign shift_en = accept;
`endif

  shift_in_reg #(
    .WIDTH(WIDTH)
  ) u_shift_in_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shift_en),
    .clear(handshake),
    .din  (in_bit),
    .q    (sr_q)
  );

  // in_ready stays low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = last_bit ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (last_bit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (last_bit) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // out_data is only loaded on HOLD entry, so it keeps the last word afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (last_bit) begin
      out_valid <= 1'b1;
`ifdef SHIFT_DEMUX_PARITY_EN
      out_data  <= sr_q;
`else
      out_data  <= {in_bit, sr_q[WIDTH-1:1]};
`endif
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHIFT_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_perr <= 1'b0;
    end else if (last_bit) begin
      out_perr <= ^{sr_q, in_bit};
    end
  end
`endif

endmodule

// File: tb/tb_shift_demux_deser.sv
// Self-checking bench for shift_demux_deser against a queue-based word model.
// Honors SHIFT_DEMUX_PARITY_EN the same way as the design.
module tb_shift_demux_deser;
  import shift_demux_pkg::*;

  localparam int W = 8;
`ifdef SHIFT_DEMUX_PARITY_EN
  localparam int TOTAL = W + 1;
  localparam int CW    = calc_cnt_w(W + 1);
`else
  localparam int TOTAL = W;
  localparam int CW    = calc_cnt_w(W);
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [W-1:0]  out_data;
  logic [CW-1:0] bit_cnt;
`ifdef SHIFT_DEMUX_PARITY_EN
  logic          out_perr;
`endif

  shift_demux_deser #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy),
    .bit_cnt  (bit_cnt)
`ifdef SHIFT_DEMUX_PARITY_EN
    ,
    .out_perr (out_perr)
`endif
  );

  always #5 clk = ~clk;

  // Model: bits received so far for the current word, plus the pending word.
  bit           m_bits[$];
  logic         m_pending = 1'b0;
  logic         m_ready_en = 1'b0;
  logic         m_perr = 1'b0;
  logic [W-1:0] m_word = '0;

  int           checks = 0;
  int           errors = 0;
  logic         check_en = 1'b0;
  logic         prev_valid = 1'b0;
  longint       rise_t[$];
  logic [W-1:0] rise_word[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pending  = 1'b0;
    m_ready_en = 1'b0;
    m_perr     = 1'b0;
    m_word     = '0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic r, output logic acc);
    logic         hs;
    logic [W-1:0] w;
    hs  = m_pending && r;
    acc = v && m_ready_en && !m_pending;
    m_ready_en = 1'b1;
    if (hs) m_pending = 1'b0;
    if (acc) begin
      m_bits.push_back(b);
      if (m_bits.size() == TOTAL) begin
        w = '0;
        for (int i = 0; i < W; i++) w[i] = m_bits[i];
        m_word = w;
`ifdef SHIFT_DEMUX_PARITY_EN
        m_perr = (^w) ^ m_bits[W];
`endif
        m_pending = 1'b1;
        m_bits.delete();
      end
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, return at next negedge.
  task automatic apply_stimulus(input logic v, input logic b, input logic r, output logic acc);
    in_valid  = v;
    in_bit    = b;
    out_ready = r;
    @(posedge clk);
    model_step(v, b, r, acc);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] word, input logic par,
                           input int gap_mode, input int rdy_mode);
    int   idx;
    int   guard;
    logic v, b, r, acc;
    idx   = 0;
    guard = 0;
    while (idx < TOTAL && guard < 200) begin
      b = (idx < W) ? word[idx] : par;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (rdy_mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      apply_stimulus(v, b, r, acc);
      if (acc) idx++;
      guard++;
    end
    check("send_progress", idx, TOTAL);
  endtask

  task automatic do_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare process: DUT outputs against the model every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("in_ready", in_ready, m_ready_en && !m_pending);
      check("out_valid", out_valid, m_pending);
      check("out_data", out_data, m_word);
      check("bit_cnt", bit_cnt, m_bits.size());
      check("busy", busy, m_bits.size() != 0);
`ifdef SHIFT_DEMUX_PARITY_EN
      if (m_pending) check("out_perr", out_perr, m_perr);
`endif
      if (out_valid && !prev_valid) begin
        rise_t.push_back($time);
        rise_word.push_back(out_data);
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic acc;
    int   g;
    check_en = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("init_out_valid", out_valid, 1'b0);
    check("init_out_data", out_data, 0);
    check("init_bit_cnt", bit_cnt, 0);
    check("init_busy", busy, 1'b0);
    check("init_in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] word 9A, continuous");
    send_word(8'h9A, ^8'h9A, 0, 1);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 8'h9A);
    apply_stimulus(1'b0, 1'b0, 1'b1, acc);
    check("t1_idle_valid", out_valid, 1'b0);
    check("t1_idle_ready", in_ready, 1'b1);
    check("t1_keep_data", out_data, 8'h9A);

    $display("[TB] word F0, consumer stalled");
    send_word(8'hF0, ^8'hF0, 0, 0);
    repeat (5) apply_stimulus(1'b1, 1'b1, 1'b0, acc);
    check("t2_valid", out_valid, 1'b1);
    check("t2_data", out_data, 8'hF0);
    check("t2_in_ready", in_ready, 1'b0);
    check("t2_bit_cnt", bit_cnt, 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, acc);

    $display("[TB] word 3C, gappy input");
    send_word(8'h3C, ^8'h3C, 1, 1);
    check("t3_data", out_data, 8'h3C);
    apply_stimulus(1'b0, 1'b0, 1'b1, acc);

    $display("[TB] reset mid-word");
    repeat (4) apply_stimulus(1'b1, 1'b1, 1'b1, acc);
    check("t4_partial_cnt", bit_cnt, 4);
    do_reset();
    send_word(8'h01, ^8'h01, 0, 1);
    check("t4_data", out_data, 8'h01);
    apply_stimulus(1'b0, 1'b0, 1'b1, acc);

    $display("[TB] back-to-back AA, 55");
    rise_t.delete();
    rise_word.delete();
    send_word(8'hAA, ^8'hAA, 0, 1);
    send_word(8'h55, ^8'h55, 0, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, acc);
    check("t5_pulses", rise_t.size(), 2);
    if (rise_t.size() == 2) begin
      check("t5_spacing", 32'((rise_t[1] - rise_t[0]) / 10), 9);
      check("t5_word0", rise_word[0], 8'hAA);
      check("t5_word1", rise_word[1], 8'h55);
    end

`ifdef SHIFT_DEMUX_PARITY_EN
    $display("[TB] parity checks");
    send_word(8'h07, 1'b1, 0, 1);
    check("par_good_perr", out_perr, 1'b0);
    check("par_good_data", out_data, 8'h07);
    apply_stimulus(1'b0, 1'b0, 1'b1, acc);
    send_word(8'h07, 1'b0, 0, 1);
    check("par_bad_perr", out_perr, 1'b1);
    check("par_bad_data", out_data, 8'h07);
    apply_stimulus(1'b0, 1'b0, 1'b1, acc);
`endif

    $display("[TB] randomized words");
    repeat (30) begin
      send_word(W'($urandom), 1'($urandom_range(0, 1)), 2, 2);
    end
    g = 0;
    while (m_pending && g < 50) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, acc);
      g++;
    end
    check("drain_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
